// File: rtl/hci_log_xbar_rr_pkg.sv
// hci_log_xbar_rr_pkg: shared policy type, latency limit and address-decode helpers
// for the logarithmic crossbar.
package hci_log_xbar_rr_pkg;

  typedef enum logic {
    HCI_ARB_RR   = 1'b0,
    HCI_ARB_PRIO = 1'b1
  } hci_arb_policy_e;

  localparam int unsigned MEM_LAT_MAX = 4;

  // Bank index: the bw_sel bits sitting just above the byte offset.
  function automatic logic [63:0] hci_bank_idx(input logic [63:0] add,
                                               input int unsigned boff,
                                               input int unsigned bw_sel);
    logic [63:0] mask;
    mask = (64'd1 << bw_sel) - 64'd1;
    return (add >> boff) & mask;
  endfunction

  // Word address within the bank; the caller keeps only the low AWM bits.
  function automatic logic [63:0] hci_word_addr(input logic [63:0] add,
                                                input int unsigned boff,
                                                input int unsigned bw_sel);
    return add >> (boff + bw_sel);
  endfunction

endpackage

// File: rtl/hci_log_xbar_rr_arbiter.sv
// hci_rr_arbiter: per-bank rotating-pointer arbiter with optional high-priority group
// and a starvation override that beats both.
module hci_rr_arbiter
  import hci_log_xbar_rr_pkg::*;
#(
  parameter int unsigned N_IN = 20,
  parameter int unsigned IW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_IN-1:0] req_i,
  input  logic [N_IN-1:0] hi_mask_i,
  input  logic [N_IN-1:0] starve_i,
  input  hci_arb_policy_e policy_i,
  input  logic            gnt_i,
  output logic [IW-1:0]   winner_o,
  output logic            valid_o
);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [N_IN-1:0] cand;
  logic [N_IN-1:0] starving;
  logic            found;

  always_comb begin
    starving = req_i & starve_i;
    if (policy_i == HCI_ARB_PRIO && |(req_i & hi_mask_i)) cand = req_i & hi_mask_i;
    else                                                  cand = req_i;
    winner_o = '0;
    found    = 1'b0;
    if (|starving) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (!found && starving[i]) begin
          winner_o = IW'(i);
          found    = 1'b1;
        end
      end
    end else begin
      // First pass covers ptr_q..N_IN-1, second pass the wrapped part below ptr_q.
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (!found && cand[i] && i >= 32'(ptr_q)) begin
          winner_o = IW'(i);
          found    = 1'b1;
        end
      end
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (!found && cand[i]) begin
          winner_o = IW'(i);
          found    = 1'b1;
        end
      end
    end
    valid_o = |req_i;
    ptr_d   = ptr_q;
    if (valid_o && gnt_i) begin
      ptr_d = (32'(winner_o) == N_IN - 1) ? '0 : winner_o + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hci_log_xbar_rr.sv
// hci_log_xbar_rr: N_IN initiators to N_BANK word-interleaved banks with per-bank RR
// arbitration and a fixed-latency response pipe. Optional: HCI_LOGXBAR_STARVE_GUARD_EN.
module hci_log_xbar_rr
  import hci_log_xbar_rr_pkg::*;
#(
  parameter int unsigned N_IN      = 20,
  parameter int unsigned N_HI      = 16,
  parameter int unsigned N_BANK    = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned AWM       = 12,
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     arb_policy_i,
  input  logic [N_IN-1:0]          in_req_i,
  input  logic [N_IN*AW-1:0]       in_add_i,
  input  logic [N_IN-1:0]          in_wen_i,
  input  logic [N_IN*DW-1:0]       in_data_i,
  input  logic [N_IN*(DW/8)-1:0]   in_be_i,
  output logic [N_IN-1:0]          in_gnt_o,
  output logic [N_IN-1:0]          in_r_valid_o,
  output logic [N_IN*DW-1:0]       in_r_data_o,
  output logic [N_BANK-1:0]        mem_req_o,
  output logic [N_BANK*AWM-1:0]    mem_add_o,
  output logic [N_BANK-1:0]        mem_wen_o,
  output logic [N_BANK*DW-1:0]     mem_data_o,
  output logic [N_BANK*(DW/8)-1:0] mem_be_o,
  input  logic [N_BANK-1:0]        mem_gnt_i,
  input  logic [N_BANK*DW-1:0]     mem_r_data_i
);

  localparam int unsigned BEW    = DW / 8;
  localparam int unsigned BOFF   = (BEW > 1) ? $clog2(BEW) : 0;
  localparam int unsigned BW_SEL = $clog2(N_BANK);
  localparam int unsigned IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned LAT    = (MEM_LAT < 1) ? 1 :
                                   (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

  typedef logic [$clog2(MAX_STALL+1)-1:0] stall_cnt_t;

  logic [N_IN-1:0]   req_eff;
  logic [BW_SEL-1:0] bank_sel [N_IN];
  logic [AWM-1:0]    word_add [N_IN];
  logic [DW-1:0]     ch_data  [N_IN];
  logic [BEW-1:0]    ch_be    [N_IN];
  logic [N_IN-1:0]   bank_req [N_BANK];
  logic [N_IN-1:0]   hi_mask;
  logic [N_IN-1:0]   starve;
  logic [IW-1:0]     win      [N_BANK];
  logic [N_BANK-1:0] win_vld;
  logic [N_BANK-1:0] hs;
  logic              rv_q     [N_BANK][LAT];
  logic [IW-1:0]     ridx_q   [N_BANK][LAT];

  // Requests are masked during reset so every combinational output reads low.
  always_comb begin
    req_eff = in_req_i & {N_IN{rst_ni}};
    for (int unsigned i = 0; i < N_IN; i++) begin
      bank_sel[i] = BW_SEL'(hci_bank_idx(64'(in_add_i[i*AW +: AW]), BOFF, BW_SEL));
      word_add[i] = AWM'(hci_word_addr(64'(in_add_i[i*AW +: AW]), BOFF, BW_SEL));
      ch_data[i]  = in_data_i[i*DW +: DW];
      ch_be[i]    = in_be_i[i*BEW +: BEW];
      hi_mask[i]  = (i < N_HI);
    end
    for (int unsigned b = 0; b < N_BANK; b++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        bank_req[b][i] = req_eff[i] && (32'(bank_sel[i]) == b);
      end
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    hci_rr_arbiter #(
      .N_IN (N_IN),
      .IW   (IW)
    ) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (bank_req[b]),
      .hi_mask_i (hi_mask),
      .starve_i  (starve),
      .policy_i  (hci_arb_policy_e'(arb_policy_i)),
      .gnt_i     (mem_gnt_i[b]),
      .winner_o  (win[b]),
      .valid_o   (win_vld[b])
    );
  end

  always_comb begin
    mem_req_o  = '0;
    mem_add_o  = '0;
    mem_wen_o  = '0;
    mem_data_o = '0;
    mem_be_o   = '0;
    for (int unsigned b = 0; b < N_BANK; b++) begin
      if (win_vld[b]) begin
        mem_req_o[b]               = 1'b1;
        mem_add_o[b*AWM +: AWM]    = word_add[win[b]];
        mem_wen_o[b]               = in_wen_i[win[b]];
        mem_data_o[b*DW +: DW]     = ch_data[win[b]];
        mem_be_o[b*BEW +: BEW]     = ch_be[win[b]];
      end
    end
    hs = win_vld & mem_gnt_i;
  end

  always_comb begin
    in_gnt_o = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      in_gnt_o[i] = req_eff[i] && win_vld[bank_sel[i]] &&
                    (win[bank_sel[i]] == IW'(i)) && mem_gnt_i[bank_sel[i]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned b = 0; b < N_BANK; b++) begin
        for (int unsigned s = 0; s < LAT; s++) begin
          rv_q[b][s]   <= 1'b0;
          ridx_q[b][s] <= '0;
        end
      end
    end else begin
      for (int unsigned b = 0; b < N_BANK; b++) begin
        rv_q[b][0]   <= hs[b];
        ridx_q[b][0] <= win[b];
        for (int unsigned s = 1; s < LAT; s++) begin
          rv_q[b][s]   <= rv_q[b][s-1];
          ridx_q[b][s] <= ridx_q[b][s-1];
        end
      end
    end
  end

  always_comb begin
    in_r_valid_o = '0;
    in_r_data_o  = '0;
    for (int unsigned b = 0; b < N_BANK; b++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (rst_ni && rv_q[b][LAT-1] && ridx_q[b][LAT-1] == IW'(i)) begin
          in_r_valid_o[i]          = 1'b1;
          in_r_data_o[i*DW +: DW]  = mem_r_data_i[b*DW +: DW];
        end
      end
    end
  end

`ifdef HCI_LOGXBAR_STARVE_GUARD_EN
  stall_cnt_t stall_q [N_IN];
  stall_cnt_t stall_d [N_IN];

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      starve[i] = (stall_q[i] == stall_cnt_t'(MAX_STALL));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      stall_d[i] = '0;
      if (req_eff[i] && !in_gnt_o[i]) begin
        stall_d[i] = starve[i] ? stall_q[i] : stall_q[i] + stall_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < N_IN; i++) stall_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) stall_q[i] <= stall_d[i];
    end
  end
`else
  always_comb starve = '0;
`endif

endmodule

// File: tb/tb_hci_log_xbar_rr.sv
// Self-checking bench for hci_log_xbar_rr: directed scenarios plus a randomized run
// compared against a behavioural arbitration/response model.
`timescale 1ns/1ps
module tb_hci_log_xbar_rr;

  localparam int N_IN      = 4;
  localparam int N_HI      = 2;
  localparam int N_BANK    = 4;
  localparam int AW        = 32;
  localparam int AWM       = 12;
  localparam int DW        = 32;
  localparam int BEW       = DW / 8;
  localparam int MEM_LAT   = 2;
  localparam int MAX_STALL = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  arb_policy;
  logic [N_IN-1:0]       in_req, in_wen, in_gnt, in_r_valid;
  logic [N_IN*AW-1:0]    in_add;
  logic [N_IN*DW-1:0]    in_data, in_r_data;
  logic [N_IN*BEW-1:0]   in_be;
  logic [N_BANK-1:0]     mem_req, mem_wen, mem_gnt;
  logic [N_BANK*AWM-1:0] mem_add;
  logic [N_BANK*DW-1:0]  mem_data, mem_r_data;
  logic [N_BANK*BEW-1:0] mem_be;

  always #5 clk = ~clk;

  hci_log_xbar_rr #(
    .N_IN      (N_IN),
    .N_HI      (N_HI),
    .N_BANK    (N_BANK),
    .AW        (AW),
    .AWM       (AWM),
    .DW        (DW),
    .MEM_LAT   (MEM_LAT),
    .MAX_STALL (MAX_STALL)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .arb_policy_i (arb_policy),
    .in_req_i     (in_req),
    .in_add_i     (in_add),
    .in_wen_i     (in_wen),
    .in_data_i    (in_data),
    .in_be_i      (in_be),
    .in_gnt_o     (in_gnt),
    .in_r_valid_o (in_r_valid),
    .in_r_data_o  (in_r_data),
    .mem_req_o    (mem_req),
    .mem_add_o    (mem_add),
    .mem_wen_o    (mem_wen),
    .mem_data_o   (mem_data),
    .mem_be_o     (mem_be),
    .mem_gnt_i    (mem_gnt),
    .mem_r_data_i (mem_r_data)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state.
  typedef struct { int due; int ch; int bank; } resp_t;
  resp_t pend [$];
  int    ptr_m   [N_BANK];
  int    stall_m [N_IN];
  int    win_m   [N_BANK];
  logic [N_IN-1:0]    exp_gnt, exp_rv;
  logic [N_BANK-1:0]  exp_mreq;
  logic [N_IN*DW-1:0] exp_rdata;

  function automatic int bank_of(int ch);
    logic [AW-1:0] a;
    a = in_add[ch*AW +: AW];
    return int'((a / BEW) % N_BANK);
  endfunction

  function automatic int word_of(int ch);
    logic [AW-1:0] a;
    a = in_add[ch*AW +: AW];
    return int'((a / BEW / N_BANK) % (1 << AWM));
  endfunction

  // Winner = eligible requester closest to the bank pointer going upward (mod N_IN).
  function automatic int pick(int b);
    int best;
    int bestd;
    int d;
    bit any_hi;
    best   = -1;
    bestd  = N_IN + 1;
    any_hi = 1'b0;
    if (!rst_n) return -1;
`ifdef HCI_LOGXBAR_STARVE_GUARD_EN
    for (int c = 0; c < N_IN; c++)
      if (in_req[c] && bank_of(c) == b && stall_m[c] >= MAX_STALL) return c;
`endif
    for (int c = 0; c < N_IN; c++)
      if (in_req[c] && bank_of(c) == b && c < N_HI) any_hi = 1'b1;
    for (int c = 0; c < N_IN; c++) begin
      if (!(in_req[c] && bank_of(c) == b)) continue;
      if (arb_policy && any_hi && c >= N_HI) continue;
      d = (c - ptr_m[b] + N_IN) % N_IN;
      if (d < bestd) begin
        bestd = d;
        best  = c;
      end
    end
    return best;
  endfunction

  task automatic model_eval();
    int b;
    exp_gnt   = '0;
    exp_rv    = '0;
    exp_rdata = '0;
    exp_mreq  = '0;
    for (int k = 0; k < N_BANK; k++) begin
      win_m[k] = pick(k);
      if (win_m[k] >= 0) exp_mreq[k] = 1'b1;
    end
    for (int c = 0; c < N_IN; c++) begin
      if (in_req[c] && rst_n) begin
        b = bank_of(c);
        if (win_m[b] == c && mem_gnt[b]) exp_gnt[c] = 1'b1;
      end
    end
    if (rst_n) begin
      foreach (pend[k]) begin
        if (pend[k].due == cyc) begin
          exp_rv[pend[k].ch] = 1'b1;
          exp_rdata[pend[k].ch*DW +: DW] = mem_r_data[pend[k].bank*DW +: DW];
        end
      end
    end
  endtask

  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic tick();
    resp_t keep [$];
    model_eval();
    @(posedge clk);
    if (!rst_n) begin
      for (int b = 0; b < N_BANK; b++) ptr_m[b] = 0;
      for (int c = 0; c < N_IN; c++) stall_m[c] = 0;
      pend.delete();
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        if (win_m[b] >= 0 && mem_gnt[b]) begin
          ptr_m[b] = (win_m[b] + 1) % N_IN;
          pend.push_back('{due: cyc + MEM_LAT, ch: win_m[b], bank: b});
        end
      end
      for (int c = 0; c < N_IN; c++) begin
        if (in_req[c] && !exp_gnt[c]) stall_m[c] = (stall_m[c] < MAX_STALL) ? stall_m[c] + 1 : MAX_STALL;
        else                          stall_m[c] = 0;
      end
    end
    cyc++;
    foreach (pend[k]) if (pend[k].due >= cyc) keep.push_back(pend[k]);
    pend = keep;
    #1;
  endtask

  task automatic set_ch(int c, logic req, logic [AW-1:0] addr, logic wen);
    in_req[c]            = req;
    in_add[c*AW +: AW]   = addr;
    in_wen[c]            = wen;
    in_data[c*DW +: DW]  = $urandom;
    in_be[c*BEW +: BEW]  = BEW'($urandom);
  endtask

  task automatic clear_inputs();
    arb_policy = 1'b0;
    in_req     = '0;
    in_add     = '0;
    in_wen     = '0;
    in_data    = '0;
    in_be      = '0;
    mem_gnt    = '1;
    for (int b = 0; b < N_BANK; b++) mem_r_data[b*DW +: DW] = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    settle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    for (int c = 0; c < N_IN; c++) set_ch(c, 1'b1, $urandom, 1'b1);
    settle();
    checks++; if (in_gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%h exp=0", in_gnt); end
    checks++; if (in_r_valid !== '0) begin failures++; $display("FAIL reset_rvalid got=%h exp=0", in_r_valid); end
    checks++; if (mem_req !== '0) begin failures++; $display("FAIL reset_mreq got=%h exp=0", mem_req); end
    checks++; if (in_r_data !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", in_r_data); end
    tick();
    tick();
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_decode();
    do_reset();
    set_ch(0, 1'b1, 32'h14, 1'b1);
    settle();
    checks++; if (mem_req !== 4'b0010) begin failures++; $display("FAIL decode_mreq got=%h exp=2", mem_req); end
    checks++; if (mem_add[1*AWM +: AWM] !== 12'h001) begin failures++; $display("FAIL decode_madd got=%h exp=001", mem_add[1*AWM +: AWM]); end
    checks++; if (mem_wen[1] !== 1'b1) begin failures++; $display("FAIL decode_mwen got=%b exp=1", mem_wen[1]); end
    checks++; if (in_gnt !== 4'b0001) begin failures++; $display("FAIL decode_gnt got=%h exp=1", in_gnt); end
    tick();
    in_req = '0;
    settle();
    checks++; if (in_r_valid !== '0) begin failures++; $display("FAIL decode_early_rvalid got=%h exp=0", in_r_valid); end
    tick();
    mem_r_data[1*DW +: DW] = 32'hDEADBEEF;
    settle();
    checks++; if (in_r_valid !== 4'b0001) begin failures++; $display("FAIL decode_rvalid got=%h exp=1", in_r_valid); end
    checks++; if (in_r_data !== {96'h0, 32'hDEADBEEF}) begin failures++; $display("FAIL decode_rdata got=%h exp=deadbeef", in_r_data); end
    tick();
  endtask

  task automatic test_rr_policy0();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N_IN-1:0] e;
    do_reset();
    for (int c = 0; c < N_IN; c++) set_ch(c, 1'b1, 32'(c * 64), 1'b1);
    for (int k = 0; k < 5; k++) begin
      settle();
      e = N_IN'(1) << order[k];
      checks++; if (in_gnt !== e) begin failures++; $display("FAIL rr_order[%0d] got=%h exp=%h", k, in_gnt, e); end
      tick();
    end
    in_req = '0;
  endtask

  task automatic test_prio();
`ifdef HCI_LOGXBAR_STARVE_GUARD_EN
    int n = MAX_STALL;
`else
    int n = 6;
`endif
    do_reset();
    arb_policy = 1'b1;
    set_ch(1, 1'b1, 32'h8, 1'b1);
    set_ch(3, 1'b1, 32'h8, 1'b0);
    for (int k = 0; k < n; k++) begin
      settle();
      checks++; if (in_gnt !== 4'b0010) begin failures++; $display("FAIL prio_hi[%0d] got=%h exp=2", k, in_gnt); end
      tick();
    end
    arb_policy = 1'b0;
    settle();
    checks++; if (in_gnt !== 4'b1000) begin failures++; $display("FAIL prio_switch got=%h exp=8", in_gnt); end
    tick();
    in_req = '0;
  endtask

  task automatic test_stall();
    logic [N_IN-1:0] e;
    do_reset();
    set_ch(1, 1'b1, 32'h0, 1'b1);
    settle();
    tick();
    in_req = '0;
    for (int k = 0; k < 2; k++) begin
      settle();
      tick();
    end
    set_ch(0, 1'b1, 32'h40, 1'b1);
    set_ch(2, 1'b1, 32'h80, 1'b1);
    mem_gnt[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (in_gnt !== '0) begin failures++; $display("FAIL stall_gnt[%0d] got=%h exp=0", k, in_gnt); end
      checks++; if (in_r_valid !== '0) begin failures++; $display("FAIL stall_rvalid[%0d] got=%h exp=0", k, in_r_valid); end
      checks++; if (mem_req[0] !== 1'b1) begin failures++; $display("FAIL stall_mreq[%0d] got=%b exp=1", k, mem_req[0]); end
      tick();
    end
    mem_gnt[0] = 1'b1;
    settle();
`ifdef HCI_LOGXBAR_STARVE_GUARD_EN
    e = 4'b0001;
`else
    e = 4'b0100;
`endif
    checks++; if (in_gnt !== e) begin failures++; $display("FAIL stall_release got=%h exp=%h", in_gnt, e); end
    tick();
    in_req = '0;
  endtask

  task automatic test_multi_bank();
    do_reset();
    for (int c = 0; c < N_IN; c++) set_ch(c, 1'b1, 32'(c * 4 + 32'h100), c[0]);
    settle();
    checks++; if (in_gnt !== 4'b1111) begin failures++; $display("FAIL multi_gnt got=%h exp=f", in_gnt); end
    checks++; if (mem_req !== 4'b1111) begin failures++; $display("FAIL multi_mreq got=%h exp=f", mem_req); end
    tick();
    in_req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ch(0, 1'b1, 32'h0, 1'b1);
    settle();
    checks++; if (in_gnt !== 4'b0001) begin failures++; $display("FAIL rstmid_gnt got=%h exp=1", in_gnt); end
    tick();
    rst_n  = 1'b0;
    in_req = '1;
    settle();
    checks++; if (in_gnt !== '0) begin failures++; $display("FAIL rstmid_gnt_low got=%h exp=0", in_gnt); end
    checks++; if (mem_req !== '0) begin failures++; $display("FAIL rstmid_mreq got=%h exp=0", mem_req); end
    checks++; if (in_r_valid !== '0) begin failures++; $display("FAIL rstmid_rvalid got=%h exp=0", in_r_valid); end
    tick();
    rst_n  = 1'b1;
    in_req = '0;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (in_r_valid !== '0) begin failures++; $display("FAIL rstmid_late_rvalid[%0d] got=%h exp=0", k, in_r_valid); end
      tick();
    end
  endtask

`ifdef HCI_LOGXBAR_STARVE_GUARD_EN
  task automatic test_starve();
    logic [N_IN-1:0] e;
    do_reset();
    arb_policy = 1'b1;
    set_ch(0, 1'b1, 32'h0, 1'b1);
    set_ch(3, 1'b1, 32'hC0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      settle();
      e = (k == 3) ? 4'b1000 : 4'b0001;
      checks++; if (in_gnt !== e) begin failures++; $display("FAIL starve[%0d] got=%h exp=%h", k, in_gnt, e); end
      tick();
    end
    in_req = '0;
  endtask
`endif

  task automatic test_random();
    int w;
    logic [AWM+1+DW+BEW-1:0] fe, fa;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      arb_policy = 1'($urandom_range(0, 1));
      for (int c = 0; c < N_IN; c++) set_ch(c, 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom));
      for (int b = 0; b < N_BANK; b++) begin
        mem_gnt[b] = ($urandom_range(0, 4) != 0);
        mem_r_data[b*DW +: DW] = $urandom;
      end
      settle();
      checks++; if (in_gnt !== exp_gnt) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%h exp=%h", cyc, in_gnt, exp_gnt); end
      checks++; if (mem_req !== exp_mreq) begin failures++; $display("FAIL rnd_mreq cyc=%0d got=%h exp=%h", cyc, mem_req, exp_mreq); end
      checks++; if (in_r_valid !== exp_rv) begin failures++; $display("FAIL rnd_rvalid cyc=%0d got=%h exp=%h", cyc, in_r_valid, exp_rv); end
      checks++; if (in_r_data !== exp_rdata) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, in_r_data, exp_rdata); end
      for (int b = 0; b < N_BANK; b++) begin
        w = win_m[b];
        if (w >= 0) begin
          fe = {AWM'(word_of(w)), in_wen[w], in_data[w*DW +: DW], in_be[w*BEW +: BEW]};
          fa = {mem_add[b*AWM +: AWM], mem_wen[b], mem_data[b*DW +: DW], mem_be[b*BEW +: BEW]};
          checks++; if (fa !== fe) begin failures++; $display("FAIL rnd_bank%0d cyc=%0d got=%h exp=%h", b, cyc, fa, fe); end
        end
      end
      tick();
    end
    in_req = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    for (int b = 0; b < N_BANK; b++) ptr_m[b] = 0;
    for (int c = 0; c < N_IN; c++) stall_m[c] = 0;
    #1;
    test_reset();
    test_decode();
    test_rr_policy0();
    test_prio();
    test_stall();
    test_multi_bank();
    test_reset_mid();
`ifdef HCI_LOGXBAR_STARVE_GUARD_EN
    test_starve();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hci_log_xbar_rr.md
Name: hci_log_xbar_rr

Overview:
- Parametrised next-generation logarithmic interconnect: N_IN initiator channels to N_BANK word-interleaved memory banks, all in one clock domain.
- Provides:
  - a per-bank round-robin arbiter with rotating pointer;
  - a selectable fixed-priority channel-group mode;
  - a configurable fixed bank read latency;
  - a per-bank response-routing pipeline.
- Sits between HCI cores and cluster TCDM banks. Replaces the fixed-latency-1 crossbar.

Parameters:
- N_IN, 20, number of initiator channels.
- N_HI, 16, channels 0..N_HI-1 form the high-priority group (policy 1). Range 0..N_IN.
- N_BANK, 32, number of banks; must be a power of 2, >=2.
- AW, 32, initiator byte-address width.
- AWM, 12, bank word-address width.
- DW, 32, data width; must be a multiple of 8.
- MEM_LAT, 1, cycles from bank grant to bank r_data. Range 1..4.
- MAX_STALL, 15, starvation threshold in cycles (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- arb_policy_i  in  1  0 = round-robin over all channels; 1 = high-priority group strictly first, round-robin within each group
- in_req_i  in  N_IN  request
- in_add_i  in  N_IN*AW  byte address
- in_wen_i  in  N_IN  1 = read, 0 = write
- in_data_i  in  N_IN*DW  write data
- in_be_i  in  N_IN*DW/8  byte enables
- in_gnt_o  out  N_IN  grant
- in_r_valid_o  out  N_IN  response valid
- in_r_data_o  out  N_IN*DW  read data
- mem_req_o  out  N_BANK  bank request
- mem_add_o  out  N_BANK*AWM  bank word address
- mem_wen_o  out  N_BANK  bank read/write select
- mem_data_o  out  N_BANK*DW  bank write data
- mem_be_o  out  N_BANK*DW/8  bank byte enables
- mem_gnt_i  in  N_BANK  bank ready
- mem_r_data_i  in  N_BANK*DW  bank read data

Behaviour:
- Address decode:
  - BOFF = log2(DW/8); BW_SEL = log2(N_BANK).
  - Bank = add[BOFF +: BW_SEL]; bank word address = add[BOFF+BW_SEL +: AWM].
  - Bits above that field are ignored.
- Request path is combinational. The winning channel's add/wen/data/be drive the bank. mem_req_o = OR of requests targeting that bank.
- in_gnt_o[i] = in_req_i[i] & winner(bank(i))==i & mem_gnt_i[bank(i)], in the same cycle.
- Round-robin arbitration, per bank:
  - ptr_q, width log2(N_IN), resets to 0.
  - Winner = first requester at index >= ptr_q, wrapping around.
  - On a handshake (mem_req_o & mem_gnt_i), ptr_q <= winner+1 mod N_IN.
  - With no handshake (no request, or mem_gnt_i low), ptr_q holds.
- Policy 1:
  - If any high-priority channel requests the bank, the winner is chosen among high-priority channels only, else among the rest.
  - Both groups share the bank's ptr_q.
  - N_HI=0 or N_HI=N_IN degenerates to policy 0.
- arb_policy_i may change on any cycle and takes effect in the same cycle. No state is cleared.
- Response pipeline, per bank:
  - Shift register of depth MEM_LAT carrying {valid, winner index}.
  - Stage 0 is loaded on every cycle with {handshake, winner}.
  - Reset clears every valid bit to 0.
- Response delivery:
  - After MEM_LAT cycles, in_r_valid_o[idx] = 1 and in_r_data_o[idx] = mem_r_data_i[bank].
  - This applies to reads and writes; for writes the data is don't-care.
  - An initiator receives at most one response per cycle, because it holds at most one grant per cycle.
- Non-responding channels drive in_r_data_o = 0.
- Reset values:
  - in_gnt_o, in_r_valid_o, mem_req_o are 0 while rst_ni is low. Combinational outputs are forced low during reset.
  - in_r_data_o is 0.
- Reset mid-transaction: in-flight responses are discarded and are never delivered.
- Simultaneous requests to different banks are all granted in the same cycle (no cross-bank coupling).

Optional Feature:
- Macro: HCI_LOGXBAR_STARVE_GUARD_EN.
- Defined:
  - Per-channel saturating stall counter, width log2(MAX_STALL+1).
  - The counter increments while in_req_i & ~in_gnt_o, and clears on a grant or when the request drops.
  - A channel whose counter equals MAX_STALL overrides the policy and group selection. The lowest-indexed starved channel per bank wins.
  - ptr_q updates as normal.
- Undefined: no counters; pure policy arbitration; MAX_STALL is unused.

Decomposition:
- hci_package receives:
  - the arb policy enum (HCI_ARB_RR=0, HCI_ARB_PRIO=1);
  - a function for bank-index and word-address extraction;
  - the MEM_LAT_MAX=4 constant.
- Sub-module hci_rr_arbiter:
  - one instance per bank;
  - inputs: req vector, high-priority mask, policy, starve vector;
  - outputs: winner index, valid;
  - contains ptr_q.

Test Plan:
- N_IN=4, N_BANK=4, DW=32: ch0 reads byte address 0x14 → mem_req_o[1]=1, mem_add_o[1]=0x1, gnt same cycle; with MEM_LAT=2, in_r_valid_o[0]=1 two cycles later carrying bank 1 data 0xDEADBEEF.
- Policy 0: ch0..3 all target bank 0 continuously, mem_gnt_i=1 → grant order 0,1,2,3,0; each channel is granted exactly once per 4 cycles.
- Policy 1, N_HI=2: ch1 and ch3 request bank 2 → ch1 granted every cycle; ch3 never granted while ch1 requests.
- Bank stall: mem_gnt_i[0]=0 for 3 cycles with ch2 requesting → no gnt, no r_valid, ptr_q unchanged; grant on the cycle gnt rises.
- Reset asserted 1 cycle after a grant with MEM_LAT=3 → no in_r_valid_o afterwards; all outputs 0 during reset.
- With HCI_LOGXBAR_STARVE_GUARD_EN, MAX_STALL=3, policy 1, ch0 (high-priority) continuously requesting bank 0 and ch3 (low-priority) requesting bank 0 → ch3 granted on its 4th request cycle.
